// File: rtl/hazard_pkg.sv
// hazard_pkg: scoreboard entry type, default parameters and entry aging helper
package hazard_pkg;
    localparam int NREG_DEF   = 32;
    localparam int DEPTH_DEF  = 3;
    localparam int TW_DEF     = 2;
    localparam int MD_LAT_DEF = 5;
    localparam int FWD_RF     = 0;
    // Entry fields are sized for the largest supported configuration (NREG<=256, TW<=8)
    localparam int FW         = 8;
    typedef struct packed {
        logic          vld;
        logic [FW-1:0] dst;
        logic [FW-1:0] tnew;
        logic [FW-1:0] rs;
        logic [FW-1:0] rt;
    } sb_entry_t;
    function automatic sb_entry_t age_entry(sb_entry_t e);
        sb_entry_t a = e;
        a.tnew = (e.tnew != '0) ? e.tnew - 1'b1 : '0;
        return a;
    endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest-match priority search over stages start..DEPTH
module hazard_match import hazard_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic [FW-1:0] src,
    input  sb_entry_t     ent [1:DEPTH],
    input  logic [SW-1:0] start,
    output logic          hit,
    output logic [SW-1:0] k,
    output logic [FW-1:0] tnew
);
    logic unused_rsrt;
    // Scan oldest to youngest so the youngest matching stage is the last one written
    always_comb begin
        hit = 1'b0;
        k = '0;
        tnew = '0;
        unused_rsrt = 1'b0;
        for (int i = DEPTH; i >= 1; i--) begin
            unused_rsrt = unused_rsrt ^ (^{ent[i].rs, ent[i].rt});
            if (i >= int'(start) && ent[i].vld && ent[i].dst == src && src != '0) begin
                hit = 1'b1;
                k = SW'(i);
                tnew = ent[i].tnew;
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard scoreboard with stall/forward selects; HAZARD_MD_EN enables the mult/div busy tracker
module hazard_scoreboard import hazard_pkg::*; #(
    parameter int NREG   = NREG_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TW     = TW_DEF,
    parameter int MD_LAT = MD_LAT_DEF,
    localparam int RW = $clog2(NREG),
    localparam int SW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          d_valid,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [RW-1:0] d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md,
    input  logic          d_md_start,
    output logic          stall,
    output logic [SW-1:0] fwd_d_rs,
    output logic [SW-1:0] fwd_d_rt,
    output logic [SW-1:0] fwd_e_rs,
    output logic [SW-1:0] fwd_e_rt,
    output logic          md_busy
);
    sb_entry_t     sb [1:DEPTH];
    logic [FW-1:0] src [4];
    logic [3:0]    hit;
    logic [SW-1:0] k [4];
    logic [FW-1:0] tn [4];
    logic          haz_stall;
    logic          md_stall;
    logic          accept;

    assign src[0] = FW'(d_rs);
    assign src[1] = FW'(d_rt);
    assign src[2] = sb[1].rs;
    assign src[3] = sb[1].rt;

    // Sources 0/1 are D operands (search from E), 2/3 are E operands (search from M)
    for (genvar g = 0; g < 4; g++) begin : g_match
        hazard_match #(.DEPTH(DEPTH)) u_match (
            .src  (src[g]),
            .ent  (sb),
            .start(SW'(g < 2 ? 1 : 2)),
            .hit  (hit[g]),
            .k    (k[g]),
            .tnew (tn[g])
        );
    end

    assign haz_stall = d_valid && ((hit[0] && tn[0] > FW'(d_tuse_rs)) || (hit[1] && tn[1] > FW'(d_tuse_rt)));
    assign stall     = haz_stall || md_stall;
    assign accept    = d_valid && !stall;
    assign fwd_d_rs  = (hit[0] && tn[0] == '0) ? k[0] : SW'(FWD_RF);
    assign fwd_d_rt  = (hit[1] && tn[1] == '0) ? k[1] : SW'(FWD_RF);
    assign fwd_e_rs  = (sb[1].vld && hit[2] && tn[2] == '0) ? k[2] : SW'(FWD_RF);
    assign fwd_e_rt  = (sb[1].vld && hit[3] && tn[3] == '0) ? k[3] : SW'(FWD_RF);

    // Advance the scoreboard one stage per cycle; a stalled or empty D becomes a bubble in E
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int i = 1; i <= DEPTH; i++) sb[i] <= '0;
        end else begin
            sb[1] <= accept ? '{vld: 1'b1, dst: FW'(d_dst), tnew: FW'(d_tnew), rs: FW'(d_rs), rt: FW'(d_rt)} : '0;
            for (int i = 2; i <= DEPTH; i++) sb[i] <= age_entry(sb[i-1]);
        end
    end

`ifdef HAZARD_MD_EN
    localparam int CW = $clog2(MD_LAT + 1);
    logic [CW-1:0] md_cnt;
    assign md_busy  = md_cnt != '0;
    assign md_stall = d_valid && d_md && md_busy;
    // Busy countdown, reloaded only when a start actually leaves D
    always_ff @(posedge clk) begin
        if (!clear_n) md_cnt <= '0;
        else if (accept && d_md_start) md_cnt <= CW'(MD_LAT);
        else if (md_busy) md_cnt <= md_cnt - 1'b1;
    end
`else
    logic unused_md;
    assign unused_md = d_md ^ d_md_start;
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic against an in-flight instruction model
module tb_hazard_scoreboard;
    localparam int NREG   = 32;
    localparam int DEPTH  = 3;
    localparam int TW     = 2;
    localparam int MD_LAT = 5;
    localparam int RW     = $clog2(NREG);
    localparam int SW     = $clog2(DEPTH + 1);
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          d_valid = 1'b0;
    logic [RW-1:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic [TW-1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
    logic          d_md = 1'b0, d_md_start = 1'b0;
    logic          stall, md_busy;
    logic [SW-1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .TW(TW), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .clear_n(clear_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_start(d_md_start), .stall(stall), .fwd_d_rs(fwd_d_rs),
        .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // Model: the instruction that entered E s+1 edges ago sits in hist[s] with its issue-time tnew
    typedef struct {bit vld; int dst; int tnew; int rs; int rt;} ent_t;
    ent_t hist [DEPTH];
    int   md_age = MD_LAT;
    int   n_chk = 0, n_pass = 0;
    bit   stall_e;
    bit   cur_v, cur_ms;
    int   cur_rs, cur_rt, cur_dst, cur_tn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void youngest(input int src, input int from, output int k, output int tn);
        k = 0;
        tn = 0;
        if (src != 0)
            for (int s = DEPTH; s >= from; s--)
                if (hist[s-1].vld && hist[s-1].dst == src) begin
                    k = s;
                    tn = (hist[s-1].tnew > s - 1) ? hist[s-1].tnew - (s - 1) : 0;
                end
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input int tur, input int tut,
                         input int dst, input int tn, input bit md, input bit ms);
        int kr, tr, kt, tt, ke, te, fer, fet;
        bit busy_e;
        d_valid = v; d_rs = RW'(rs); d_rt = RW'(rt); d_tuse_rs = TW'(tur); d_tuse_rt = TW'(tut);
        d_dst = RW'(dst); d_tnew = TW'(tn); d_md = md; d_md_start = ms;
        cur_v = v; cur_rs = rs; cur_rt = rt; cur_dst = dst; cur_tn = tn; cur_ms = ms;
        #1;
        youngest(rs, 1, kr, tr);
        youngest(rt, 1, kt, tt);
        busy_e = MD_EN && md_age < MD_LAT;
        stall_e = v && ((kr != 0 && tr > tur) || (kt != 0 && tt > tut) || (md && busy_e));
        fer = 0;
        fet = 0;
        if (hist[0].vld) begin
            youngest(hist[0].rs, 2, ke, te);
            fer = (ke != 0 && te == 0) ? ke : 0;
            youngest(hist[0].rt, 2, ke, te);
            fet = (ke != 0 && te == 0) ? ke : 0;
        end
        chk("stall", 32'(stall), 32'(stall_e));
        chk("md_busy", 32'(md_busy), 32'(busy_e));
        chk("fwd_d_rs", 32'(fwd_d_rs), (kr != 0 && tr == 0) ? kr : 0);
        chk("fwd_d_rt", 32'(fwd_d_rt), (kt != 0 && tt == 0) ? kt : 0);
        chk("fwd_e_rs", 32'(fwd_e_rs), fer);
        chk("fwd_e_rt", 32'(fwd_e_rt), fet);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!clear_n) begin
            for (int s = 0; s < DEPTH; s++) hist[s].vld = 0;
            md_age = MD_LAT;
        end else begin
            for (int s = DEPTH - 1; s > 0; s--) hist[s] = hist[s-1];
            hist[0] = '{vld: cur_v && !stall_e, dst: cur_dst, tnew: cur_tn, rs: cur_rs, rt: cur_rt};
            if (cur_v && !stall_e && cur_ms && MD_EN) md_age = 0;
            else if (md_age < MD_LAT) md_age++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        int cnt;
        for (int s = 0; s < DEPTH; s++) hist[s] = '{vld: 0, dst: 0, tnew: 0, rs: 0, rt: 0};
        clear_n = 1'b0;
        idle(2);
        clear_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_md_busy", 32'(md_busy), 0);
        chk("reset_fwd", 32'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}), 0);
        tick();
        // addu $3 (tnew 1) then a reader of $3 with tuse 1
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 3, 1, 1, 8, 1, 0, 0);
        chk("s1_stall", 32'(stall), 0);
        chk("s1_fwd_d_rt", 32'(fwd_d_rt), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s1_fwd_e_rs", 32'(fwd_e_rs), 2);
        tick();
        idle(DEPTH + 1);
        // lw $5 (tnew 2) followed by a reader with tuse 1
        drive(1, 0, 0, 0, 0, 5, 2, 0, 0);
        tick();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("s2_stall", 32'(stall), 1);
        tick();
        drive(1, 5, 0, 1, 1, 6, 1, 0, 0);
        chk("s2_stall_released", 32'(stall), 0);
        chk("s2_bubble_fwd_e", 32'(fwd_e_rs), 0);
        tick();
        idle(DEPTH + 1);
        // ori $7 (tnew 1) then beq reading $7 at tuse 0
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_stall", 32'(stall), 1);
        tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("s3_stall_released", 32'(stall), 0);
        chk("s3_fwd_d_rs", 32'(fwd_d_rs), 2);
        tick();
        idle(DEPTH + 1);
        // $4 written twice: the youngest writer wins; $0 never matches
        drive(1, 0, 0, 0, 0, 4, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 4, 0, 0, 0);
        tick();
        drive(1, 4, 0, 0, 0, 0, 2, 0, 0);
        chk("s4_fwd_d_rs", 32'(fwd_d_rs), 1);
        chk("s4_fwd_d_rt_zero", 32'(fwd_d_rt), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s4_zero_no_stall", 32'(stall), 0);
        tick();
        idle(DEPTH + 1);
        // mult then mflo
        drive(1, 1, 2, 0, 0, 0, 0, 1, 1);
        tick();
        cnt = 0;
        drive(1, 0, 0, 0, 0, 2, 0, 1, 0);
        chk("s5_md_busy", 32'(md_busy), 32'(MD_EN));
        chk("s5_stall", 32'(stall), 32'(MD_EN));
        for (int i = 0; i < MD_LAT + 3; i++) begin
            if (i > 0) drive(1, 0, 0, 0, 0, 2, 0, 1, 0);
            if (md_busy) cnt++;
            tick();
        end
        chk("s5_busy_cycles", cnt, MD_EN ? MD_LAT : 0);
        idle(DEPTH + 1);
        // reset while stalled and while the multiplier is busy
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 0, 5, 2, 0, 0);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 1, 0);
        chk("s6_stall_before", 32'(stall), 1);
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        drive(1, 5, 0, 0, 0, 0, 0, 1, 0);
        chk("s6_stall_after", 32'(stall), 0);
        chk("s6_md_busy_after", 32'(md_busy), 0);
        chk("s6_fwd_after", 32'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}), 0);
        tick();
        // random traffic over a small register set so matches are frequent
        for (int i = 0; i < 500; i++) begin
            bit md, ms;
            ms = ($urandom_range(0, 19) == 0);
            md = ms || ($urandom_range(0, 9) == 0);
            clear_n = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
                  $urandom_range(0, 3), md, ms);
            tick();
        end
        clear_n = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
